// File: rtl/act_sigmoid_bwd_if.sv
// rtl/act_sigmoid_bwd_if.sv - gradient stream and bias-gradient bundle for act_sigmoid_bwd
interface act_sigmoid_bwd_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_y;
    logic [15:0]      in_g;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_delta;
    logic             out_clamp;
    logic             out_last;
    logic             bias_valid;
    logic [ACC_W-1:0] bias_grad;
    logic [CNT_W-1:0] bias_cnt;

    modport master (
        output in_valid, in_y, in_g, in_last, out_ready,
        input  in_ready, out_valid, out_delta, out_clamp, out_last,
        input  bias_valid, bias_grad, bias_cnt
    );

    modport slave (
        input  in_valid, in_y, in_g, in_last, out_ready,
        output in_ready, out_valid, out_delta, out_clamp, out_last,
        output bias_valid, bias_grad, bias_cnt
    );
endinterface

// File: rtl/act_sigmoid_bwd.sv
// rtl/act_sigmoid_bwd.sv - Q8.8 sigmoid backward pass, delta = g*y*(1-y), per-frame bias gradient; ACT_BWD_ROUND_EN selects rounding
module act_sigmoid_bwd #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    act_sigmoid_bwd_if.slave bus
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic [6:0]       s1_d_q, s1_d_d;
    logic [15:0]      s1_g_q, s1_g_d;
    logic             s1_clamp_q, s1_clamp_d;
    logic             s1_last_q, s1_last_d;
    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      s2_delta_q, s2_delta_d;
    logic             s2_clamp_q, s2_clamp_d;
    logic             s2_last_q, s2_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bias_valid_q, bias_valid_d;
    logic [ACC_W-1:0] bias_grad_q, bias_grad_d;
    logic [CNT_W-1:0] bias_cnt_q, bias_cnt_d;

    logic             adv1, adv2, xfer;
    logic [8:0]       yc;
    logic             y_clamp;
    logic signed [23:0] prod;
    logic [15:0]      delta_calc;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] acc_next;

    // Handshake: a stage advances when it is empty or the stage after it drains
    always_comb begin
        adv2 = !s2_valid_q || bus.out_ready;
        adv1 = !s1_valid_q || adv2;
        xfer = s2_valid_q && bus.out_ready;
    end

    // Stage 1: clamp y into 0..1.0 and form d = yc*(1-yc) in Q8.8 (0..0x40)
    always_comb begin
        yc         = bus.in_y[8:0];
        y_clamp    = 1'b0;
        if (bus.in_y[15]) begin
            yc      = 9'd0;
            y_clamp = 1'b1;
        end else if (bus.in_y > 16'h0100) begin
            yc      = 9'h100;
            y_clamp = 1'b1;
        end
        s1_valid_d = s1_valid_q;
        s1_d_d     = s1_d_q;
        s1_g_d     = s1_g_q;
        s1_clamp_d = s1_clamp_q;
        s1_last_d  = s1_last_q;
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d_d     = 7'((18'(yc) * (18'h100 - 18'(yc))) >> 8);
                s1_g_d     = bus.in_g;
                s1_clamp_d = y_clamp;
                s1_last_d  = bus.in_last;
            end
        end
    end

    // Stage 2: delta = g*d scaled back to Q8.8; |delta| <= 0x2000 so no saturation
    always_comb begin
        prod = $signed({{8{s1_g_q[15]}}, s1_g_q}) * $signed({17'd0, s1_d_q});
`ifdef ACT_BWD_ROUND_EN
        delta_calc = 16'((prod + 24'sd128) >>> 8);
`else
        delta_calc = 16'(prod >>> 8);
`endif
        s2_valid_d = s2_valid_q;
        s2_delta_d = s2_delta_q;
        s2_clamp_d = s2_clamp_q;
        s2_last_d  = s2_last_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_delta_d = delta_calc;
                s2_clamp_d = s1_clamp_q;
                s2_last_d  = s1_last_q;
            end
        end
    end

    // Bias accumulator: sticky saturating sum of transferred deltas, published on the last beat
    always_comb begin
        sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){s2_delta_q[15]}}, s2_delta_q};
        ovf      = sum[ACC_W] ^ sum[ACC_W-1];
        acc_next = sum[ACC_W-1:0];
        if (sat_q) begin
            acc_next = acc_q;
        end else if (ovf) begin
            acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        acc_d        = acc_q;
        sat_d        = sat_q;
        cnt_d        = cnt_q;
        bias_valid_d = 1'b0;
        bias_grad_d  = bias_grad_q;
        bias_cnt_d   = bias_cnt_q;
        if (xfer) begin
            if (s2_last_q) begin
                bias_valid_d = 1'b1;
                bias_grad_d  = acc_next;
                bias_cnt_d   = cnt_q + CNT_W'(1);
                acc_d        = '0;
                sat_d        = 1'b0;
                cnt_d        = '0;
            end else begin
                acc_d = acc_next;
                sat_d = sat_q || ovf;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards pipeline and any partial frame at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_d_q       <= '0;
            s1_g_q       <= '0;
            s1_clamp_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_delta_q   <= '0;
            s2_clamp_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            cnt_q        <= '0;
            bias_valid_q <= 1'b0;
            bias_grad_q  <= '0;
            bias_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_d_q       <= s1_d_d;
            s1_g_q       <= s1_g_d;
            s1_clamp_q   <= s1_clamp_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_delta_q   <= s2_delta_d;
            s2_clamp_q   <= s2_clamp_d;
            s2_last_q    <= s2_last_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            cnt_q        <= cnt_d;
            bias_valid_q <= bias_valid_d;
            bias_grad_q  <= bias_grad_d;
            bias_cnt_q   <= bias_cnt_d;
        end
    end

    assign bus.in_ready   = adv1;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_delta  = s2_delta_q;
    assign bus.out_clamp  = s2_clamp_q;
    assign bus.out_last   = s2_last_q;
    assign bus.bias_valid = bias_valid_q;
    assign bus.bias_grad  = bias_grad_q;
    assign bus.bias_cnt   = bias_cnt_q;

endmodule

// File: tb/tb_act_sigmoid_bwd.sv
// tb/tb_act_sigmoid_bwd.sv - self-checking bench for act_sigmoid_bwd
module tb_act_sigmoid_bwd;
    localparam int ACC_W = 24;
    localparam int CNT_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    act_sigmoid_bwd_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    act_sigmoid_bwd_if #(.ACC_W(16), .CNT_W(CNT_W)) bus16 ();

    act_sigmoid_bwd #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    act_sigmoid_bwd #(.ACC_W(16), .CNT_W(CNT_W)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] stim_y[$];
    logic [15:0] stim_g[$];
    logic        stim_last[$];
    logic [17:0] exp_q[$];

    int m_acc, m_cnt, m_bias_grad, m_bias_cnt;
    bit m_sat;

    function automatic logic [15:0] ref_delta(input logic [15:0] y, input logic [15:0] g);
        int yc, d, p, q;
        if (y[15]) yc = 0;
        else if (y > 16'h0100) yc = 256;
        else yc = int'(y);
        d = (yc * (256 - yc)) / 256;
        p = int'($signed(g)) * d;
`ifdef ACT_BWD_ROUND_EN
        p = p + 128;
`endif
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q[15:0];
    endfunction

    function automatic logic ref_clamp(input logic [15:0] y);
        return (y[15] == 1'b1) || (y > 16'h0100);
    endfunction

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_sat = 0;
        exp_q.delete();
    endtask

    task automatic model_xfer(input logic [15:0] d, input logic last);
        int maxv;
        int minv;
        maxv = (1 << (ACC_W - 1)) - 1;
        minv = -(1 << (ACC_W - 1));
        if (!m_sat) begin
            m_acc = m_acc + int'($signed(d));
            if (m_acc > maxv) begin m_acc = maxv; m_sat = 1; end
            else if (m_acc < minv) begin m_acc = minv; m_sat = 1; end
        end
        m_cnt = m_cnt + 1;
        if (last) begin
            m_bias_grad = m_acc;
            m_bias_cnt  = m_cnt % (1 << CNT_W);
            m_acc = 0; m_cnt = 0; m_sat = 0;
        end
    endtask

    // rmode: 0 ready high, 1 toggle, 2 random; vmode: 0 continuous valid, 1 random gaps
    task automatic run_stream(input int rmode, input int vmode, input int budget);
        int idx = 0;
        int cyc = 0;
        bit bias_pend = 0;
        logic [17:0] e;
        while ((idx < stim_y.size() || exp_q.size() > 0 || bias_pend) && cyc < budget) begin
            @(posedge clk); #1;
            bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (idx < stim_y.size() && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_y = stim_y[idx]; bus.in_g = stim_g[idx]; bus.in_last = stim_last[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (bus.bias_valid !== bias_pend) $display("FAIL bias_valid cyc=%0d got=%b want=%b", cyc, bus.bias_valid, bias_pend);
            else n_pass++;
            if (bias_pend) begin
                n_checks++;
                if (bus.bias_grad !== 24'(m_bias_grad)) $display("FAIL bias_grad got=%h want=%h", bus.bias_grad, 24'(m_bias_grad));
                else n_pass++;
                n_checks++;
                if (bus.bias_cnt !== 12'(m_bias_cnt)) $display("FAIL bias_cnt got=%0d want=%0d", bus.bias_cnt, m_bias_cnt);
                else n_pass++;
            end
            bias_pend = 0;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_beat got delta=%h want none", bus.out_delta);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_clamp, bus.out_delta} !== e)
                        $display("FAIL beat got last=%b clamp=%b delta=%h want last=%b clamp=%b delta=%h",
                                 bus.out_last, bus.out_clamp, bus.out_delta, e[17], e[16], e[15:0]);
                    else n_pass++;
                    model_xfer(e[15:0], e[17]);
                    bias_pend = e[17];
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({stim_last[idx], ref_clamp(stim_y[idx]), ref_delta(stim_y[idx], stim_g[idx])});
                idx++;
            end
            cyc++;
        end
        n_checks++;
        if (cyc >= budget) $display("FAIL stream_timeout got pending=%0d want 0", exp_q.size() + stim_y.size() - idx);
        else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        stim_y.delete(); stim_g.delete(); stim_last.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.in_y = 0; bus.in_g = 0; bus.in_last = 0; bus.out_ready = 0;
        bus16.in_valid = 0; bus16.in_y = 0; bus16.in_g = 0; bus16.in_last = 0; bus16.out_ready = 0;
        #12;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_delta, bus.out_clamp, bus.out_last, bus.bias_valid} !== {1'b1, 1'b0, 16'h0, 3'b000})
            $display("FAIL reset_outputs got rdy=%b ov=%b d=%h c=%b l=%b bv=%b want 1 0 0000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_delta, bus.out_clamp, bus.out_last, bus.bias_valid);
        else n_pass++;
        n_checks++;
        if (bus.bias_grad !== 24'h0 || bus.bias_cnt !== 12'h0)
            $display("FAIL reset_bias got grad=%h cnt=%h want 000000 000", bus.bias_grad, bus.bias_cnt);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_y = 16'h0080; bus.in_g = 16'h0100; bus.in_last = 1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL lat_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL lat_early got=%b want=0", bus.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_delta !== 16'h0040 || bus.out_last !== 1'b1)
            $display("FAIL lat_out got v=%b d=%h l=%b want 1 0040 1", bus.out_valid, bus.out_delta, bus.out_last);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.bias_valid !== 1'b1 || bus.bias_grad !== 24'h000040 || bus.bias_cnt !== 12'd1)
            $display("FAIL lat_bias got bv=%b g=%h c=%0d want 1 000040 1", bus.bias_valid, bus.bias_grad, bus.bias_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.bias_valid !== 1'b0 || bus.bias_grad !== 24'h000040)
            $display("FAIL lat_bias_pulse got bv=%b g=%h want 0 000040", bus.bias_valid, bus.bias_grad);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] ty[6];
        logic [15:0] tg[6];
        logic [15:0] td[6];
        logic        tc[6];
        ty = '{16'h0040, 16'h01C0, 16'h8000, 16'h0080, 16'h0100, 16'h0000};
        tg = '{16'hFF00, 16'h0100, 16'h0100, 16'h0003, 16'h0100, 16'h7FFF};
`ifdef ACT_BWD_ROUND_EN
        td = '{16'hFFD0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
`else
        td = '{16'hFFD0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        tc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.out_ready = 1; bus.in_valid = 1; bus.in_y = ty[i]; bus.in_g = tg[i]; bus.in_last = 1;
            @(negedge clk);
            @(posedge clk); #1;
            bus.in_valid = 0;
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_delta !== td[i] || bus.out_clamp !== tc[i])
                $display("FAIL directed[%0d] y=%h got v=%b d=%h c=%b want 1 %h %b",
                         i, ty[i], bus.out_valid, bus.out_delta, bus.out_clamp, td[i], tc[i]);
            else n_pass++;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int acc_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.out_ready = 0; bus.in_valid = 1; bus.in_y = 16'h0080;
            bus.in_g = (acc_n == 0) ? 16'h0100 : 16'h0200;
            bus.in_last = (acc_n == 1);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({bus.in_last, ref_clamp(bus.in_y), ref_delta(bus.in_y, bus.in_g)});
                acc_n++;
            end
            if (c >= 2) begin
                n_checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_delta !== 16'h0040)
                    $display("FAIL stall_hold c=%0d got rdy=%b v=%b d=%h want 0 1 0040", c, bus.in_ready, bus.out_valid, bus.out_delta);
                else n_pass++;
            end
        end
        n_checks++;
        if (acc_n != 2) $display("FAIL stall_depth got=%0d want=2", acc_n); else n_pass++;
        run_stream(0, 0, 50);
        n_checks++;
        if (bus.bias_grad !== 24'h0000C0 || bus.bias_cnt !== 12'd2)
            $display("FAIL stall_bias got g=%h c=%0d want 0000c0 2", bus.bias_grad, bus.bias_cnt);
        else n_pass++;
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 8; i++) begin
            stim_y.push_back(16'h0080); stim_g.push_back(16'h0100); stim_last.push_back(i == 7);
        end
        run_stream(1, 0, 200);
        n_checks++;
        if (bus.bias_grad !== 24'h000200 || bus.bias_cnt !== 12'd8)
            $display("FAIL toggle_bias got g=%h c=%0d want 000200 8", bus.bias_grad, bus.bias_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lens[3] = '{1, 1, 3};
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < lens[f]; i++) begin
                stim_y.push_back(16'($urandom_range(0, 256)));
                stim_g.push_back(16'($urandom));
                stim_last.push_back(i == lens[f] - 1);
            end
        run_stream(0, 0, 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) stim_y.push_back(16'($urandom));
            else stim_y.push_back(16'($urandom_range(0, 256)));
            stim_g.push_back(16'($urandom));
            stim_last.push_back((i == 39) || ($urandom_range(0, 6) == 0));
        end
        run_stream(2, 1, 2000);
    endtask

    task automatic test_saturation();
        int sent = 0, pulses = 0, cyc = 0, m = 0;
        bit msat = 0;
        logic [15:0] d;
        d = ref_delta(16'h0080, 16'h7FFF);
        for (int i = 0; i < 1000; i++)
            if (!msat) begin
                m = m + int'($signed(d));
                if (m > 32767) begin m = 32767; msat = 1; end
            end
        while ((sent < 1000 || pulses == 0) && cyc < 1100) begin
            @(posedge clk); #1;
            bus16.out_ready = 1;
            bus16.in_valid = (sent < 1000);
            bus16.in_y = 16'h0080; bus16.in_g = 16'h7FFF; bus16.in_last = (sent == 999);
            @(negedge clk);
            if (bus16.bias_valid) begin
                pulses++;
                n_checks++;
                if (bus16.bias_grad !== 16'(m) || bus16.bias_cnt !== 12'd1000)
                    $display("FAIL sat_bias got g=%h c=%0d want %h 1000", bus16.bias_grad, bus16.bias_cnt, 16'(m));
                else n_pass++;
            end
            if (bus16.in_valid && bus16.in_ready) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        bus16.in_valid = 0;
        n_checks++;
        if (sent != 1000 || pulses != 1) $display("FAIL sat_done got sent=%0d pulses=%0d want 1000 1", sent, pulses);
        else n_pass++;
        n_checks++;
        if (bus16.bias_grad !== 16'h7FFF) $display("FAIL sat_value got=%h want=7fff", bus16.bias_grad);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int sent = 0, cyc = 0;
        while (sent < 3 && cyc < 20) begin
            @(posedge clk); #1;
            bus.out_ready = 1; bus.in_valid = 1; bus.in_y = 16'h0080; bus.in_g = 16'h0100; bus.in_last = 0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_delta, bus.out_last, bus.bias_valid} !== {1'b1, 1'b0, 16'h0, 2'b00})
            $display("FAIL midrst_outputs got rdy=%b v=%b d=%h l=%b bv=%b want 1 0 0000 0 0",
                     bus.in_ready, bus.out_valid, bus.out_delta, bus.out_last, bus.bias_valid);
        else n_pass++;
        n_checks++;
        if (bus.bias_grad !== 24'h0 || bus.bias_cnt !== 12'h0)
            $display("FAIL midrst_bias got g=%h c=%h want 000000 000", bus.bias_grad, bus.bias_cnt);
        else n_pass++;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stim_y.push_back(16'h0080); stim_g.push_back(16'h0100); stim_last.push_back(i == 1);
        end
        run_stream(0, 0, 50);
        n_checks++;
        if (bus.bias_cnt !== 12'd2 || bus.bias_grad !== 24'h000080)
            $display("FAIL midrst_next got c=%0d g=%h want 2 000080", bus.bias_cnt, bus.bias_grad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_stall();
        test_toggle();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
